// File: rtl/mem_arb_if.sv
// mem_arb_if -- bundle of all handshake/bus signals around mem_arb.
//   ifu_*  : instruction-fetch request/grant/read-data channel
//   lsu_*  : load/store request/grant/read-data channel
//   mem_*  : single-ported memory command/acknowledge channel
// Modports:
//   slave  : the arbiter (consumes requests and mem_ack, drives grants/mem_*)
//   master : requesters plus the memory model (the arbiter's environment)
// CPU6_XLEN falls back to 32 when the core does not define it.
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

interface mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = `CPU6_XLEN
);
  logic            ifu_req;
  logic [AW-1:0]   ifu_addr;
  logic            ifu_gnt;
  logic            ifu_rvalid;
  logic [DW-1:0]   ifu_rdata;

  logic            lsu_req;
  logic            lsu_we;
  logic [AW-1:0]   lsu_addr;
  logic [DW-1:0]   lsu_wdata;
  logic [DW/8-1:0] lsu_wstrb;
  logic            lsu_gnt;
  logic            lsu_rvalid;
  logic [DW-1:0]   lsu_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  ifu_req, ifu_addr,
    output ifu_gnt, ifu_rvalid, ifu_rdata,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
    output lsu_gnt, lsu_rvalid, lsu_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport master (
    output ifu_req, ifu_addr,
    input  ifu_gnt, ifu_rvalid, ifu_rdata,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
    input  lsu_gnt, lsu_rvalid, lsu_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb -- two-port (IFU/LSU) arbiter and sequencer for one single-ported
// memory. Picks a requester in IDLE, grants it combinationally, registers its
// command onto mem_*, holds mem_req until mem_ack, then pulses the winner's
// rvalid with the read data (0 for stores) one cycle later.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : mem_arb_if.slave (ifu_*, lsu_*, mem_* channels)
// Config macro CPU6_MEM_ARB_RR_EN: defined -> round-robin on contention
// (port not granted last wins); undefined -> fixed priority, LSU wins.
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

module mem_arb #(
  parameter int AW = 32,
  parameter int DW = `CPU6_XLEN
) (
  input  logic       clk,
  input  logic       reset,
  mem_arb_if.slave   bus
);
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t          state_q;
  logic            mem_req_q, mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [SW-1:0]   mem_wstrb_q;
  logic            ifu_rvalid_q, lsu_rvalid_q;
  logic [DW-1:0]   ifu_rdata_q, lsu_rdata_q;

  logic            idle, pick_lsu, ifu_gnt, lsu_gnt;

  // Grants are the only combinational outputs; gating with reset keeps them
  // at 0 while reset is held, like every registered output.
  assign idle = (state_q == IDLE) && reset;

`ifdef CPU6_MEM_ARB_RR_EN
  logic last_lsu_q;  // 1: most recent grant went to LSU
  assign pick_lsu = bus.lsu_req && (!bus.ifu_req || !last_lsu_q);
`else
  assign pick_lsu = bus.lsu_req;
`endif

  assign lsu_gnt = idle && pick_lsu;
  assign ifu_gnt = idle && bus.ifu_req && !pick_lsu;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
`ifdef CPU6_MEM_ARB_RR_EN
      last_lsu_q   <= 1'b0;
`endif
    end else begin
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // mem_ack is ignored here: no command is outstanding.
          if (lsu_gnt) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.lsu_we;
            mem_addr_q  <= bus.lsu_addr;
            mem_wdata_q <= bus.lsu_wdata;
            mem_wstrb_q <= bus.lsu_wstrb;
          end else if (ifu_gnt) begin
            state_q     <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.ifu_addr;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end
`ifdef CPU6_MEM_ARB_RR_EN
          if (lsu_gnt || ifu_gnt) last_lsu_q <= lsu_gnt;
`endif
        end
        BUSY_I: begin
          if (bus.mem_ack) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            ifu_rvalid_q <= 1'b1;
            ifu_rdata_q  <= bus.mem_rdata;
          end
        end
        BUSY_D: begin
          if (bus.mem_ack) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            lsu_rvalid_q <= 1'b1;
            // Store completion returns zero data.
            lsu_rdata_q  <= mem_we_q ? '0 : bus.mem_rdata;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ifu_gnt    = ifu_gnt;
  assign bus.lsu_gnt    = lsu_gnt;
  assign bus.ifu_rvalid = ifu_rvalid_q;
  assign bus.ifu_rdata  = ifu_rdata_q;
  assign bus.lsu_rvalid = lsu_rvalid_q;
  assign bus.lsu_rdata  = lsu_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb -- scoreboard bench for mem_arb. Directed stimulus pushes the
// expected grant order, memory commands and returned data into queues; a
// negedge monitor and a memory model pop and compare as the DUT produces them.
`timescale 1ns/1ps

module tb_mem_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            wait_n;
    logic [DW-1:0] rdata;
  } cmd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arb_if #(.AW(AW), .DW(DW)) bus ();
  mem_arb #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  cmd_t          ifu_stim[$], lsu_stim[$], exp_cmd[$];
  bit            exp_gnt[$];          // 0 = IFU, 1 = LSU
  logic [DW-1:0] exp_ifu[$], exp_lsu[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int ifu_gnt_cyc, ifu_rv_cyc, lsu_gnt_cyc, lsu_rv_cyc;
  bit ifu_took = 0, lsu_took = 0, b2b_arm = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string act, input string exp);
    total++;
    bad++;
    $display("FAIL %s: got %s expected %s", name, act, exp);
  endtask

  function automatic cmd_t mk(input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                              input int wait_n, input logic [DW-1:0] rdata);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata; c.wstrb = wstrb;
    c.wait_n = wait_n; c.rdata = rdata;
    return c;
  endfunction

  // Monitor: grant order and returned data.
  initial begin : mon
    forever begin
      @(negedge clk);
      cyc++;
      ifu_took = bus.ifu_gnt;
      lsu_took = bus.lsu_gnt;
      if (reset) begin
        if (bus.ifu_gnt || bus.lsu_gnt) begin
          check("gnt_onehot", {63'd0, bus.ifu_gnt & bus.lsu_gnt}, 64'd0);
          if (exp_gnt.size() == 0) fail("gnt_unexpected", "grant", "none");
          else check("gnt_port", {63'd0, bus.lsu_gnt}, {63'd0, exp_gnt.pop_front()});
          if (bus.ifu_gnt) ifu_gnt_cyc = cyc;
          if (bus.lsu_gnt) lsu_gnt_cyc = cyc;
        end
        if (bus.ifu_rvalid) begin
          ifu_rv_cyc = cyc;
          if (exp_ifu.size() == 0) fail("ifu_rvalid_unexpected", "rvalid", "none");
          else check("ifu_rdata", bus.ifu_rdata, exp_ifu.pop_front());
          if (b2b_arm) begin
            check("b2b_gnt_with_rvalid", {63'd0, bus.ifu_gnt}, 64'd1);
            b2b_arm = 0;
          end
        end
        if (bus.lsu_rvalid) begin
          lsu_rv_cyc = cyc;
          if (exp_lsu.size() == 0) fail("lsu_rvalid_unexpected", "rvalid", "none");
          else check("lsu_rdata", bus.lsu_rdata, exp_lsu.pop_front());
        end
      end
    end
  end

  // Memory model: checks the command every cycle of mem_req, acks after
  // wait_n cycles, and asserts a stray ack whenever mem_req is low.
  initial begin : mem_model
    cmd_t c;
    bit   active;
    int   cnt;
    active = 0; cnt = 0;
    c = mk(1'b0, '0, '0, '0, 1, '0);
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        active = 0;
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        if (!active) begin
          active = 1;
          cnt = 0;
          if (exp_cmd.size() == 0) begin
            fail("mem_req_unexpected", "mem_req", "none");
            c = mk(1'b0, '0, '0, '0, 1, '0);
          end else c = exp_cmd.pop_front();
        end
        check("mem_we", {63'd0, bus.mem_we}, {63'd0, c.we});
        check("mem_addr", {32'd0, bus.mem_addr}, {32'd0, c.addr});
        check("mem_wstrb", {60'd0, bus.mem_wstrb}, {60'd0, c.wstrb});
        if (c.we) check("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, c.wdata});
        cnt++;
        bus.mem_ack   = (cnt == c.wait_n);
        bus.mem_rdata = (cnt == c.wait_n) ? c.rdata : 32'hBAD0_0000 | DW'(cnt);
      end else begin
        if (active) check("mem_req_cycles", 64'(cnt), 64'(c.wait_n));
        active = 0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hF00D_F00D;
      end
    end
  end

  // Requester drivers: hold req until granted, then present the next item.
  initial begin : ifu_drv
    bus.ifu_req = 1'b0;
    bus.ifu_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.ifu_req && ifu_took) begin
        void'(ifu_stim.pop_front());
        bus.ifu_req = 1'b0;
      end
      if (!bus.ifu_req && ifu_stim.size() > 0) begin
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = ifu_stim[0].addr;
      end
    end
  end

  initial begin : lsu_drv
    bus.lsu_req = 1'b0;
    bus.lsu_we = 1'b0;
    bus.lsu_addr = '0;
    bus.lsu_wdata = '0;
    bus.lsu_wstrb = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.lsu_req && lsu_took) begin
        void'(lsu_stim.pop_front());
        bus.lsu_req = 1'b0;
      end
      if (!bus.lsu_req && lsu_stim.size() > 0) begin
        bus.lsu_req   = 1'b1;
        bus.lsu_we    = lsu_stim[0].we;
        bus.lsu_addr  = lsu_stim[0].addr;
        bus.lsu_wdata = lsu_stim[0].wdata;
        bus.lsu_wstrb = lsu_stim[0].wstrb;
      end
    end
  end

  function automatic int pending();
    return ifu_stim.size() + lsu_stim.size() + exp_gnt.size() + exp_cmd.size()
         + exp_ifu.size() + exp_lsu.size();
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (pending() != 0 || bus.mem_req) begin
      @(posedge clk);
      n++;
      if (n > budget) begin
        fail("drain_timeout", "pending work", "completion");
        ifu_stim.delete(); lsu_stim.delete(); exp_gnt.delete();
        exp_cmd.delete(); exp_ifu.delete(); exp_lsu.delete();
        return;
      end
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},    {63'd0, bus.mem_req}, 64'd0);
    check({tag, "_mem_we"},     {63'd0, bus.mem_we}, 64'd0);
    check({tag, "_mem_addr"},   {32'd0, bus.mem_addr}, 64'd0);
    check({tag, "_mem_wdata"},  {32'd0, bus.mem_wdata}, 64'd0);
    check({tag, "_mem_wstrb"},  {60'd0, bus.mem_wstrb}, 64'd0);
    check({tag, "_gnts"},       {62'd0, bus.ifu_gnt, bus.lsu_gnt}, 64'd0);
    check({tag, "_rvalids"},    {62'd0, bus.ifu_rvalid, bus.lsu_rvalid}, 64'd0);
    check({tag, "_ifu_rdata"},  {32'd0, bus.ifu_rdata}, 64'd0);
    check({tag, "_lsu_rdata"},  {32'd0, bus.lsu_rdata}, 64'd0);
  endtask

  initial begin : main
    cmd_t l0, l1, l2, i0, i1, st;
    int   n;
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("rst");
    @(negedge clk) reset = 1'b1;

    // Single fetch, 1-cycle memory.
    i0 = mk(1'b0, 32'h100, '0, '0, 1, 32'hDEAD_BEEF);
    exp_gnt.push_back(1'b0); exp_cmd.push_back(i0); exp_ifu.push_back(32'hDEAD_BEEF);
    ifu_stim.push_back(i0);
    drain(50);
    check("fetch_latency", 64'(ifu_rv_cyc - ifu_gnt_cyc), 64'd2);
    repeat (3) @(posedge clk);
    #2;
    check("ifu_rdata_hold", {32'd0, bus.ifu_rdata}, 64'hDEAD_BEEF);

    // Store with 3-cycle memory wait.
    st = mk(1'b1, 32'h40, 32'h1234, 4'hF, 3, 32'h5555_AAAA);
    exp_gnt.push_back(1'b1); exp_cmd.push_back(st); exp_lsu.push_back('0);
    lsu_stim.push_back(st);
    drain(50);
    check("store_latency", 64'(lsu_rv_cyc - lsu_gnt_cyc), 64'd4);

    // Load, 2-cycle wait.
    l0 = mk(1'b0, 32'h80, '0, 4'h0, 2, 32'hCAFE_0001);
    exp_gnt.push_back(1'b1); exp_cmd.push_back(l0); exp_lsu.push_back(32'hCAFE_0001);
    lsu_stim.push_back(l0);
    drain(50);

    // Back-to-back fetches: second grant coincides with first rvalid.
    i0 = mk(1'b0, 32'h200, '0, '0, 1, 32'h0000_0011);
    i1 = mk(1'b0, 32'h204, '0, '0, 1, 32'h0000_0022);
    b2b_arm = 1;
    exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b0);
    exp_cmd.push_back(i0); exp_cmd.push_back(i1);
    exp_ifu.push_back(32'h11); exp_ifu.push_back(32'h22);
    ifu_stim.push_back(i0); ifu_stim.push_back(i1);
    drain(50);
    check("b2b_armed_consumed", {63'd0, b2b_arm}, 64'd0);

    // Contention from a fresh reset (last-grant = IFU).
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
    l0 = mk(1'b0, 32'h300, '0, 4'h0, 1, 32'hA1A1_0001);
    l1 = mk(1'b1, 32'h304, 32'h0BAD_0002, 4'h3, 2, 32'h0);
    l2 = mk(1'b0, 32'h308, '0, 4'h0, 1, 32'hA1A1_0003);
    i0 = mk(1'b0, 32'h400, '0, '0, 1, 32'hB1B1_0001);
    i1 = mk(1'b0, 32'h404, '0, '0, 2, 32'hB1B1_0002);
`ifdef CPU6_MEM_ARB_RR_EN
    exp_gnt = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_cmd.push_back(l0); exp_cmd.push_back(i0); exp_cmd.push_back(l1);
    exp_cmd.push_back(i1); exp_cmd.push_back(l2);
`else
    exp_gnt = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_cmd.push_back(l0); exp_cmd.push_back(l1); exp_cmd.push_back(l2);
    exp_cmd.push_back(i0); exp_cmd.push_back(i1);
`endif
    exp_lsu.push_back(32'hA1A1_0001); exp_lsu.push_back('0); exp_lsu.push_back(32'hA1A1_0003);
    exp_ifu.push_back(32'hB1B1_0001); exp_ifu.push_back(32'hB1B1_0002);
    lsu_stim.push_back(l0); lsu_stim.push_back(l1); lsu_stim.push_back(l2);
    ifu_stim.push_back(i0); ifu_stim.push_back(i1);
    drain(200);

    // Reset while a store is in flight: everything drops, no rvalid.
    st = mk(1'b1, 32'h500, 32'h0000_ABCD, 4'h3, 20, 32'h0);
    exp_gnt.push_back(1'b1); exp_cmd.push_back(st);
    lsu_stim.push_back(st);
    n = 0;
    while (!bus.mem_req && n < 50) begin @(posedge clk); n++; end
    if (!bus.mem_req) fail("wait_mem_req", "no mem_req", "mem_req");
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("midrst_no_rvalid", {62'd0, bus.lsu_rvalid, bus.ifu_rvalid}, 64'd0);
    check("midrst_mem_req_low", {63'd0, bus.mem_req}, 64'd0);

    // Normal service after the abort.
    l0 = mk(1'b0, 32'h504, '0, 4'h0, 1, 32'h7777_7777);
    exp_gnt.push_back(1'b1); exp_cmd.push_back(l0); exp_lsu.push_back(32'h7777_7777);
    lsu_stim.push_back(l0);
    drain(50);

    check("queues_empty", 64'(pending()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
